// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg : shared encodings for the instruction-fetch front end
// Revision  : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package fetch_pkg;

  typedef enum logic [0:0] {
    S_WAIT  = 1'b0,
    S_VALID = 1'b1
  } fetch_state_t;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_JMP  = 2'd1,
    SEL_CALL = 2'd2,
    SEL_RET  = 2'd3
  } redir_sel_t;

  // Fixed priority: jmp over call over ret.
  function automatic redir_sel_t redir_select(input logic jmp, input logic call,
                                              input logic ret);
    if (jmp)       return SEL_JMP;
    else if (call) return SEL_CALL;
    else if (ret)  return SEL_RET;
    else           return SEL_NONE;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_return_stack.sv
// ---------------------------------------------------------------------------
// fetch_return_stack : parametrised LIFO holding call return addresses
// Revision           : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fetch_return_stack #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 12,
  parameter int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [LVL_W-1:0] level,
  output logic             full,
  output logic             empty
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [IDX_W-1:0] top_idx;
  logic [IDX_W-1:0] wr_idx;

  assign top_idx = IDX_W'(level - 1'b1);
  assign wr_idx  = IDX_W'(level);
  assign dout    = mem[top_idx];
  assign full    = (level == LVL_W'(DEPTH));
  assign empty   = (level == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level <= '0;
    end else if (push && !full) begin
      level <= level + 1'b1;
    end else if (pop && !empty) begin
      level <= level - 1'b1;
    end
  end

  // Storage needs no reset: entries are only read below the level pointer.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wr_idx] <= din;
    end
  end

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit : sequenced instruction fetch with latency, stall and call stack
// Revision   : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fetch_unit #(
  parameter int ADDR_W      = 12,
  parameter int INST_W      = 16,
  parameter int STACK_DEPTH = 8,
  parameter int MEM_LAT     = 1,
  parameter int RESET_ADDR  = 0
) (
  input  logic                               clk,
  input  logic                               reset,
  output logic [ADDR_W-1:0]                  imem_addr,
  input  logic [INST_W-1:0]                  imem_rdata,
  output logic [INST_W-1:0]                  inst,
  output logic                               inst_valid,
  output logic [ADDR_W-1:0]                  pc_out,
  input  logic                               stall,
  input  logic                               jmp,
  input  logic [ADDR_W-1:0]                  jmp_addr,
  input  logic                               call,
  input  logic                               ret,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   stack_level,
  output logic                               stack_overflow,
  output logic                               stack_underflow
);

  import fetch_pkg::*;

  localparam int LVL_W = $clog2(STACK_DEPTH + 1);
  localparam int CNT_W = 3;

  fetch_state_t      state;
  logic [CNT_W-1:0]  cnt;
  redir_sel_t        sel;
  logic              accept;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] next_pc;
  logic [ADDR_W-1:0] stk_dout;
  logic              stk_full;
  logic              stk_empty;
  logic              push;
  logic              pop;

  assign accept = (state == S_VALID) && !stall;
  assign sel    = redir_select(jmp, call, ret);
  assign pc_inc = pc_out + 1'b1;
  assign push   = accept && (sel == SEL_CALL) && !stk_full;
  assign pop    = accept && (sel == SEL_RET) && !stk_empty;

  always_comb begin
    next_pc = pc_inc;
    case (sel)
      SEL_JMP, SEL_CALL: next_pc = jmp_addr;
      SEL_RET:           next_pc = stk_empty ? pc_inc : stk_dout;
      default:           next_pc = pc_inc;
    endcase
  end

  fetch_return_stack #(
    .DEPTH (STACK_DEPTH),
    .WIDTH (ADDR_W),
    .LVL_W (LVL_W)
  ) u_stack (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (pc_inc),
    .dout  (stk_dout),
    .level (stack_level),
    .full  (stk_full),
    .empty (stk_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= S_WAIT;
      cnt             <= '0;
      imem_addr       <= ADDR_W'(RESET_ADDR);
      pc_out          <= ADDR_W'(RESET_ADDR);
      inst            <= '0;
      inst_valid      <= 1'b0;
      stack_overflow  <= 1'b0;
      stack_underflow <= 1'b0;
    end else begin
      case (state)
        S_WAIT: begin
          if (cnt == CNT_W'(MEM_LAT - 1)) begin
            inst       <= imem_rdata;
            pc_out     <= imem_addr;
            inst_valid <= 1'b1;
            cnt        <= '0;
            state      <= S_VALID;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_VALID: begin
          if (!stall) begin
            imem_addr  <= next_pc;
            inst_valid <= 1'b0;
            state      <= S_WAIT;
            // Call into a full stack still redirects; only the push is lost.
            if (sel == SEL_CALL && stk_full) stack_overflow <= 1'b1;
            if (sel == SEL_RET && stk_empty) stack_underflow <= 1'b1;
          end
        end
        default: state <= S_WAIT;
      endcase
    end
  end

endmodule

`default_nettype wire
